// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the CPU instruction memory/loader
// Purpose: widths, loader state encoding and instruction layout shared by
//          prog_mem, prog_loader_rom and the CPU core.
package cpu_pkg;

  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 8;
  localparam int DEPTH   = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    EMPTY = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } loader_state_t;

  typedef struct packed {
    logic [3:0] opecode;
    logic [3:0] imm;
  } instr_t;

endpackage

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - 16x8 program register array, sync write, async read
// Purpose: instruction storage for the CPU.
// Ports:
//   clk   - rising-edge clock
//   n_rst - synchronous active-high reset, clears every word to 0
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address (combinational read)
//   rdata - read data
module prog_mem
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader_rom.sv
// rtl/prog_loader_rom.sv - instruction ROM with byte-stream program loader
// Purpose: serves opecode/imm to the CPU combinationally and holds the CPU in
//          reset until a full 16-byte program has been loaded.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to require a 17th byte
//          equal to the mod-256 sum of the program bytes.
// Ports:
//   clk        - rising-edge clock
//   n_rst      - synchronous active-high reset (despite the name)
//   load_start - pulse: begin/restart a program load
//   load_valid - load_data holds a byte
//   load_data  - program byte, stored in address order
//   load_ready - loader accepts a byte this cycle
//   load_done  - valid program resident (RUN)
//   load_err   - checksum failure (0 without the optional feature)
//   cpu_hold   - hold the CPU in reset
//   addr       - CPU fetch address
//   opecode    - fetched opcode (0 outside RUN)
//   imm        - fetched immediate (0 outside RUN)
module prog_loader_rom
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               load_start,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_ready,
  output logic               load_done,
  output logic               load_err,
  output logic               cpu_hold,
  input  logic [ADDR_W-1:0]  addr,
  output logic [3:0]         opecode,
  output logic [3:0]         imm
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  loader_state_t     state, state_n;
  logic [ADDR_W-1:0] wptr, wptr_n;
  logic              mem_we;
  instr_t            rd_word;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [INSTR_W-1:0] sum, sum_n;
`endif

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state <= EMPTY;
      wptr  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum   <= '0;
`endif
    end else begin
      state <= state_n;
      wptr  <= wptr_n;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum   <= sum_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    wptr_n  = wptr;
    mem_we  = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_n   = sum;
`endif
    // Start wins over any byte offered in the same cycle.
    if (load_start) begin
      state_n = LOAD;
      wptr_n  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_n   = '0;
`endif
    end else begin
      case (state)
        LOAD: begin
          if (load_valid) begin
            mem_we = 1'b1;
            wptr_n = wptr + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_n  = sum + load_data;
            if (wptr == LAST_ADDR) state_n = CHECK;
`else
            if (wptr == LAST_ADDR) state_n = RUN;
`endif
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CHECK: begin
          if (load_valid) begin
            state_n = (load_data == sum) ? RUN : ERROR;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  prog_mem u_mem (
    .clk   (clk),
    .n_rst (n_rst),
    .we    (mem_we),
    .waddr (wptr),
    .wdata (load_data),
    .raddr (addr),
    .rdata (rd_word)
  );

`ifdef PROG_LOADER_CHECKSUM_EN
  assign load_ready = (state == LOAD) || (state == CHECK);
  assign load_err   = (state == ERROR);
`else
  assign load_ready = (state == LOAD);
  assign load_err   = 1'b0;
`endif
  assign load_done  = (state == RUN);
  assign cpu_hold   = (state != RUN);
  assign opecode    = (state == RUN) ? rd_word.opecode : 4'h0;
  assign imm        = (state == RUN) ? rd_word.imm     : 4'h0;

endmodule
